sd_data_reader: RTL

SD_DATA_READER -- requirements
Module: sd_data_reader

---
 rtl/sd_data_reader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_data_reader.sv
// ---------------------------------------------------------------------------
// sd_data_reader
//
// Reads one data block from an SD card in SPI mode. After READ_START the
// block watches DO for the start token (the first 0 bit after idle 1s), then
// shifts in DATA_TO_READ_LENGTH payload bits followed by the 16-bit CRC, all
// MSB first on the rising edge of CLK. Completion and timeout are sticky
// flags that hold until RESET. The block must be reset before every use.
//
// Optional feature:
//   SD_READ_CRC_CHECK_EN - when defined, CRC16-CCITT (x^16+x^12+x^5+1, init
//                          0x0000, MSB first) is computed over the payload and
//                          compared with the received CRC. When undefined, the
//                          CRC bits are still clocked past with the same
//                          timing, but they are discarded and CRC_ERROR is
//                          tied to 0.
//
// Parameters:
//   DATA_TO_READ_LENGTH - payload bits per block (1..4096)
//   TOKEN_TIMEOUT       - CLK cycles to wait for the start token (2..65535)
//
// Ports:
//   CLK          in   SD SPI clock; DO is sampled on its rising edge
//   RESET        in   asynchronous, active-high reset
//   DO           in   card serial data out (MISO)
//   READ_START   in   level request to begin a read, sampled only in IDLE
//   DI           out  card serial data in (MOSI), always 1
//   DATA_READ    out  received payload, loaded when READ_FINISH rises
//   READ_FINISH  out  sticky, the whole block has been received
//   READ_TIMEOUT out  sticky, no start token arrived in time
//   CRC_ERROR    out  sticky, received CRC mismatched (valid with READ_FINISH)
// ---------------------------------------------------------------------------
module sd_data_reader #(
  parameter int DATA_TO_READ_LENGTH = 16,
  parameter int TOKEN_TIMEOUT       = 4096
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           DO,
  input  logic                           READ_START,
  output logic                           DI,
  output logic [DATA_TO_READ_LENGTH-1:0] DATA_READ,
  output logic                           READ_FINISH,
  output logic                           READ_TIMEOUT,
  output logic                           CRC_ERROR
);

  localparam int N = DATA_TO_READ_LENGTH;

  // One bit counter serves both the payload and CRC phases, so it must hold
  // the larger of N-1 and 15. The token counter must be able to reach
  // TOKEN_TIMEOUT itself.
  localparam int CNT_MAX = (N > 16) ? N : 16;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TOKEN_TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_DATA   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_CRC    = CW'(15);
  localparam logic [TW-1:0] TOKEN_LIMIT = TW'(TOKEN_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TOKEN,
    READ_DATA,
    READ_CRC,
    FINISH,
    TIMEOUT
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] token_cnt;
  logic [TW-1:0] token_cnt_inc;
  logic [N-1:0]  data_shift;
  logic [N-1:0]  data_shift_next;
  logic [N-1:0]  data_read_q;
  logic          read_finish_q;
  logic          read_timeout_q;

  logic          start_accept;
  logic          token_seen;
  logic          token_expired;
  logic          data_done;
  logic          crc_done;

  // The card must see MOSI high for the whole data phase.
  assign DI           = 1'b1;
  assign DATA_READ    = data_read_q;
  assign READ_FINISH  = read_finish_q;
  assign READ_TIMEOUT = read_timeout_q;

  assign token_cnt_inc = token_cnt + TW'(1);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the one-cycle strobes that the datapath uses to
  // act on each transition. A 0 on DO is checked before the timeout so that
  // a token arriving on the final allowed edge still wins.
  always_comb begin
    next_state    = state;
    start_accept  = 1'b0;
    token_seen    = 1'b0;
    token_expired = 1'b0;
    data_done     = 1'b0;
    crc_done      = 1'b0;

    case (state)
      IDLE: begin
        if (READ_START) begin
          start_accept = 1'b1;
          next_state   = WAIT_TOKEN;
        end
      end
      WAIT_TOKEN: begin
        if (!DO) begin
          token_seen = 1'b1;
          next_state = READ_DATA;
        end else if (token_cnt_inc == TOKEN_LIMIT) begin
          token_expired = 1'b1;
          next_state    = TIMEOUT;
        end
      end
      READ_DATA: begin
        if (bit_cnt == LAST_DATA) begin
          data_done  = 1'b1;
          next_state = READ_CRC;
        end
      end
      READ_CRC: begin
        if (bit_cnt == LAST_CRC) begin
          crc_done   = 1'b1;
          next_state = FINISH;
        end
      end
      FINISH:  next_state = FINISH;
      TIMEOUT: next_state = TIMEOUT;
      default: next_state = IDLE;
    endcase
  end

  // Shifting through a temporary keeps this legal for a 1-bit payload, where
  // a part-select of data_shift[N-2:0] would be empty.
  always_comb begin
    data_shift_next    = data_shift << 1;
    data_shift_next[0] = DO;
  end

  // Counters, payload shift register and the sticky status flags. DATA_READ
  // is copied only on the edge that completes the CRC, so an aborted read
  // never exposes a partial payload.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt        <= '0;
      token_cnt      <= '0;
      data_shift     <= '0;
      data_read_q    <= '0;
      read_finish_q  <= 1'b0;
      read_timeout_q <= 1'b0;
    end else begin
      if (start_accept) begin
        token_cnt <= '0;
        bit_cnt   <= '0;
      end

      if (state == WAIT_TOKEN) begin
        if (token_seen) begin
          bit_cnt <= '0;
        end else begin
          token_cnt <= token_cnt_inc;
        end
      end

      if (token_expired) begin
        read_timeout_q <= 1'b1;
      end

      if (state == READ_DATA) begin
        data_shift <= data_shift_next;
        bit_cnt    <= data_done ? '0 : bit_cnt + CW'(1);
      end

      if (state == READ_CRC) begin
        bit_cnt <= bit_cnt + CW'(1);
      end

      if (crc_done) begin
        read_finish_q <= 1'b1;
        data_read_q   <= data_shift;
      end
    end
  end

`ifdef SD_READ_CRC_CHECK_EN
  logic [15:0] crc_calc;
  logic [15:0] crc_calc_next;
  logic [15:0] crc_shift;
  logic [15:0] crc_received;
  logic        crc_feedback;
  logic        crc_error_q;

  // Serial CRC16-CCITT, MSB first: feed back the outgoing MSB XOR the new
  // data bit into taps 12, 5 and 0 (0x1021).
  always_comb begin
    crc_feedback  = crc_calc[15] ^ DO;
    crc_calc_next = {crc_calc[14:0], 1'b0} ^ (crc_feedback ? 16'h1021 : 16'h0000);
    crc_received  = {crc_shift[14:0], DO};
  end

  // The last CRC bit is still on DO when the comparison is made, so the
  // received value is assembled from the shift register plus the live bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      crc_calc    <= '0;
      crc_shift   <= '0;
      crc_error_q <= 1'b0;
    end else begin
      if (token_seen) begin
        crc_calc  <= '0;
        crc_shift <= '0;
      end
      if (state == READ_DATA) begin
        crc_calc <= crc_calc_next;
      end
      if (state == READ_CRC) begin
        crc_shift <= crc_received;
      end
      if (crc_done) begin
        crc_error_q <= (crc_received != crc_calc);
      end
    end
  end

  assign CRC_ERROR = crc_error_q;
`else
  assign CRC_ERROR = 1'b0;
`endif

endmodule
